i2c_frame_packer: RTL and testbench



---
 rtl/i2c_aes_pkg.sv | 27 ++
 rtl/frame_byte_counter.sv | 54 +++++
 rtl/i2c_frame_packer.sv | 154 +++++++++++++++
 tb/tb_i2c_frame_packer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_aes_pkg.sv
// Shared types and constants for the I2C-to-AES-128 front end.
// Covers FSM state encoding, frame geometry, mode encoding and the slave address.
package i2c_aes_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int FRAME_BYTES = 2 * BLOCK_BYTES + 1;

    localparam logic       MODE_ENC   = 1'b0;
    localparam logic       MODE_DEC   = 1'b1;
    localparam logic [6:0] SLAVE_ADDR = 7'h6A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_LAUNCH,
        ST_WAIT_AES
    } state_t;

    // Field that the next incoming byte belongs to.
    typedef enum logic [1:0] {
        FIELD_DATA,
        FIELD_KEY,
        FIELD_MODE,
        FIELD_OVER
    } field_t;

endpackage

// File: rtl/frame_byte_counter.sv
// Saturating byte index for the write frame.
// Also decodes which field the next byte lands in.
module frame_byte_counter
    import i2c_aes_pkg::*;
#(
    parameter int BLOCK_BYTES = i2c_aes_pkg::BLOCK_BYTES,
    parameter int FRAME_BYTES = i2c_aes_pkg::FRAME_BYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    output logic [5:0] count,
    output field_t     field
);

    localparam logic [5:0] KEY_BASE  = 6'(BLOCK_BYTES);
    localparam logic [5:0] MODE_IDX  = 6'(2 * BLOCK_BYTES);
    localparam logic [5:0] SAT_COUNT = 6'(FRAME_BYTES + 1);

    logic [5:0] count_reg;
    logic [5:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count_reg != SAT_COUNT)) begin
            count_next = count_reg + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    always_comb begin
        field = FIELD_OVER;
        if (count_reg < KEY_BASE) begin
            field = FIELD_DATA;
        end else if (count_reg < MODE_IDX) begin
            field = FIELD_KEY;
        end else if (count_reg == MODE_IDX) begin
            field = FIELD_MODE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/i2c_frame_packer.sv
// Packs a 33-byte I2C write frame into AES data/key/mode and launches the core.
// Rejects short, long and malformed frames, and ignores bus traffic while a job runs.
module i2c_frame_packer #(
    parameter int BLOCK_BYTES = i2c_aes_pkg::BLOCK_BYTES,
    parameter int FRAME_BYTES = i2c_aes_pkg::FRAME_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     frame_start,
    input  logic                     frame_stop,
    input  logic                     aes_done,
    output logic                     aes_start,
    output logic [8*BLOCK_BYTES-1:0] aes_data,
    output logic [8*BLOCK_BYTES-1:0] aes_key,
    output logic                     aes_mode,
    output logic                     ack_ok,
    output logic                     busy,
    output logic                     frame_err
);

    import i2c_aes_pkg::*;

    localparam int W = 8 * BLOCK_BYTES;

    state_t             state_reg, state_next;
    logic               frame_err_reg, frame_err_next;
    logic               cnt_clear, cnt_inc, store;
    logic [5:0]         count;
    field_t             field;
    logic               byte_bad;
    logic               stop_len_ok;
    logic [W-1:0]       data_reg, key_reg;
    logic               mode_reg;
    logic [BLOCK_BYTES-1:0] data_we, key_we;

    frame_byte_counter #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .FRAME_BYTES (FRAME_BYTES)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (count),
        .field (field)
    );

    // A mode byte may only carry bit 0; anything past the mode byte is overflow.
    assign byte_bad = ((field == FIELD_MODE) && (byte_data[7:1] != 7'd0))
                    || (field == FIELD_OVER);

    // The stop is judged on the count after a byte arriving in the same cycle.
    assign stop_len_ok = byte_valid ? (count == 6'(FRAME_BYTES - 1))
                                    : (count == 6'(FRAME_BYTES));

    always_comb begin
        state_next     = state_reg;
        frame_err_next = frame_err_reg;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;
        store          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next     = ST_COLLECT;
                    cnt_clear      = 1'b1;
                    frame_err_next = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (frame_start) begin
                    cnt_clear      = 1'b1;
                    frame_err_next = 1'b0;
                end else begin
                    if (byte_valid) begin
                        store   = 1'b1;
                        cnt_inc = 1'b1;
                        if (byte_bad) begin
                            frame_err_next = 1'b1;
                        end
                    end
                    if (frame_stop) begin
                        if (stop_len_ok && !frame_err_next) begin
                            state_next = ST_LAUNCH;
                        end else begin
                            state_next     = ST_IDLE;
                            frame_err_next = 1'b1;
                        end
                    end
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT_AES;
            end
            ST_WAIT_AES: begin
                if (aes_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_err_reg <= frame_err_next;
        end
    end

    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte_we
        assign data_we[gi] = store && (field == FIELD_DATA) && (count == 6'(gi));
        assign key_we[gi]  = store && (field == FIELD_KEY)
                          && (count == 6'(gi + BLOCK_BYTES));
    end

    // First byte of each field lands in the most significant byte lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg <= '0;
            key_reg  <= '0;
            mode_reg <= MODE_ENC;
        end else begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (data_we[i]) begin
                    data_reg[W-1-8*i -: 8] <= byte_data;
                end
                if (key_we[i]) begin
                    key_reg[W-1-8*i -: 8] <= byte_data;
                end
            end
            if (store && (field == FIELD_MODE)) begin
                mode_reg <= byte_data[0];
            end
        end
    end

    assign aes_start = (state_reg == ST_LAUNCH);
    assign busy      = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT_AES);
    assign ack_ok    = (state_reg == ST_IDLE)
                    || ((state_reg == ST_COLLECT) && (field != FIELD_OVER));
    assign aes_data  = data_reg;
    assign aes_key   = key_reg;
    assign aes_mode  = mode_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_i2c_frame_packer.sv
// Directed bench for i2c_frame_packer: good frames, error frames, lockout and reset.
module tb_i2c_frame_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         byte_valid = 1'b0;
    logic [7:0]   byte_data = 8'h00;
    logic         frame_start = 1'b0;
    logic         frame_stop = 1'b0;
    logic         aes_done = 1'b0;
    logic         aes_start, aes_mode, ack_ok, busy, frame_err;
    logic [127:0] aes_data, aes_key;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    localparam logic [127:0] D_ENC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D_DEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;

    i2c_frame_packer dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_start (frame_start),
        .frame_stop  (frame_stop),
        .aes_done    (aes_done),
        .aes_start   (aes_start),
        .aes_data    (aes_data),
        .aes_key     (aes_key),
        .aes_mode    (aes_mode),
        .ack_ok      (ack_ok),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Launch pulses as the core would see them at each rising edge.
    always @(posedge clk) if (aes_start === 1'b1) start_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_stop;
        frame_stop = 1'b1;
        tick();
        frame_stop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_fields(input logic [127:0] d, input logic [127:0] k);
        for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8]);
        for (int i = 0; i < 16; i++) send_byte(k[127-8*i -: 8]);
    endtask

    task automatic finish_job;
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL reset_aes_start got %b expected 0", aes_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b expected 0", frame_err); end
        checks++; if (ack_ok !== 1'b1) begin errors++; $display("FAIL reset_ack_ok got %b expected 1", ack_ok); end
        checks++; if (aes_data !== 128'h0) begin errors++; $display("FAIL reset_aes_data got %h expected 0", aes_data); end
        checks++; if (aes_key !== 128'h0) begin errors++; $display("FAIL reset_aes_key got %h expected 0", aes_key); end
        checks++; if (aes_mode !== 1'b0) begin errors++; $display("FAIL reset_aes_mode got %b expected 0", aes_mode); end
        $display("test_reset done");
    endtask

    task automatic test_encrypt;
        int s0;
        s0 = start_cnt;
        pulse_start();
        send_fields(D_ENC, K1);
        send_byte(8'h00);
        pulse_stop();
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL enc_start_latency got %b expected 1", aes_start); end
        tick();
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL enc_start_width got %b expected 0", aes_start); end
        checks++; if (aes_data !== D_ENC) begin errors++; $display("FAIL enc_data got %h expected %h", aes_data, D_ENC); end
        checks++; if (aes_key !== K1) begin errors++; $display("FAIL enc_key got %h expected %h", aes_key, K1); end
        checks++; if (aes_mode !== 1'b0) begin errors++; $display("FAIL enc_mode got %b expected 0", aes_mode); end
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enc_busy_wait got %b expected 1", busy); end
        finish_job();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enc_busy_done got %b expected 0", busy); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL enc_pulse_count got %0d expected 1", start_cnt - s0); end
        $display("test_encrypt done");
    endtask

    task automatic test_decrypt;
        int s0;
        s0 = start_cnt;
        pulse_start();
        send_fields(D_DEC, K1);
        send_byte(8'h01);
        pulse_stop();
        tick();
        checks++; if (aes_data !== D_DEC) begin errors++; $display("FAIL dec_data got %h expected %h", aes_data, D_DEC); end
        checks++; if (aes_key !== K1) begin errors++; $display("FAIL dec_key got %h expected %h", aes_key, K1); end
        checks++; if (aes_mode !== 1'b1) begin errors++; $display("FAIL dec_mode got %b expected 1", aes_mode); end
        finish_job();
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL dec_pulse_count got %0d expected 1", start_cnt - s0); end
        $display("test_decrypt done");
    endtask

    task automatic test_short_frame;
        int s0;
        s0 = start_cnt;
        pulse_start();
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        pulse_stop();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_err got %b expected 1", frame_err); end
        tick();
        checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL short_no_launch got %0d expected 0", start_cnt - s0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got %b expected 0", busy); end
        pulse_start();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_err_clear got %b expected 0", frame_err); end
        pulse_stop();
        $display("test_short_frame done");
    endtask

    task automatic test_overflow;
        int s0;
        s0 = start_cnt;
        pulse_start();
        send_fields(D_DEC, K1);
        checks++; if (ack_ok !== 1'b1) begin errors++; $display("FAIL ovf_ack_byte32 got %b expected 1", ack_ok); end
        send_byte(8'h00);
        checks++; if (ack_ok !== 1'b0) begin errors++; $display("FAIL ovf_ack_byte33 got %b expected 0", ack_ok); end
        send_byte(8'h77);
        pulse_stop();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b expected 1", frame_err); end
        tick();
        checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL ovf_no_launch got %0d expected 0", start_cnt - s0); end
        $display("test_overflow done");
    endtask

    task automatic test_bad_mode;
        int s0;
        s0 = start_cnt;
        pulse_start();
        send_fields(D_ENC, K1);
        send_byte(8'h02);
        pulse_stop();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL badmode_err got %b expected 1", frame_err); end
        tick();
        checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL badmode_no_launch got %0d expected 0", start_cnt - s0); end
        $display("test_bad_mode done");
    endtask

    task automatic test_busy_lockout;
        int s0;
        pulse_start();
        send_fields(D_ENC, K1);
        send_byte(8'h00);
        pulse_stop();
        tick();
        s0 = start_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            checks++; if (ack_ok !== 1'b0) begin errors++; $display("FAIL lock_ack_%0d got %b expected 0", i, ack_ok); end
            send_byte(8'hA5);
        end
        pulse_stop();
        checks++; if (aes_data !== D_ENC) begin errors++; $display("FAIL lock_data got %h expected %h", aes_data, D_ENC); end
        checks++; if (aes_key !== K1) begin errors++; $display("FAIL lock_key got %h expected %h", aes_key, K1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy got %b expected 1", busy); end
        checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL lock_no_relaunch got %0d expected 0", start_cnt - s0); end
        finish_job();
        pulse_start();
        send_fields(D_DEC, K1);
        send_byte(8'h01);
        pulse_stop();
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL lock_after_start got %b expected 1", aes_start); end
        tick();
        checks++; if (aes_data !== D_DEC) begin errors++; $display("FAIL lock_after_data got %h expected %h", aes_data, D_DEC); end
        finish_job();
        $display("test_busy_lockout done");
    endtask

    task automatic test_reset_mid;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i));
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        rst        = 1'b0;
        tick();
        byte_valid = 1'b0;
        checks++; if (aes_data !== 128'h0) begin errors++; $display("FAIL rstmid_data got %h expected 0", aes_data); end
        checks++; if (aes_key !== 128'h0) begin errors++; $display("FAIL rstmid_key got %h expected 0", aes_key); end
        checks++; if (ack_ok !== 1'b1) begin errors++; $display("FAIL rstmid_ack got %b expected 1", ack_ok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy); end
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL rstmid_start got %b expected 0", aes_start); end
        rst = 1'b1;
        tick();
        pulse_start();
        send_fields(D_ENC, K1);
        send_byte(8'h00);
        pulse_stop();
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL rstmid_relaunch got %b expected 1", aes_start); end
        tick();
        checks++; if (aes_data !== D_ENC) begin errors++; $display("FAIL rstmid_new_data got %h expected %h", aes_data, D_ENC); end
        finish_job();
        $display("test_reset_mid done");
    endtask

    task automatic test_byte_with_stop;
        pulse_start();
        send_fields(D_DEC, K1);
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        frame_stop = 1'b1;
        tick();
        byte_valid = 1'b0;
        frame_stop = 1'b0;
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL bws_start got %b expected 1", aes_start); end
        checks++; if (aes_mode !== 1'b1) begin errors++; $display("FAIL bws_mode got %b expected 1", aes_mode); end
        tick();
        finish_job();
        $display("test_byte_with_stop done");
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_short_frame();
        test_overflow();
        test_bad_mode();
        test_busy_lockout();
        test_reset_mid();
        test_byte_with_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
